ram_io_responder: RTL and testbench

Responder end of the byte-wide CPU memory bus driven by the memory controller: serves RAM byte reads/writes and memory-mapped IO.
- 1-cycle registered read data.
- IO writes go to a UART TX byte FIFO.
- Asserts io_buffer_full so the controller stalls before the FIFO can overflow.
- Sits between the CPU top and the RAM/UART wrappers; also used as the simulation memory model.

---
 rtl/ram_io_responder_pkg.sv | 50 +++++
 rtl/ram_io_responder_byte_fifo.sv | 88 ++++++++
 rtl/ram_io_responder.sv | 135 +++++++++++++
 tb/tb_ram_io_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared constants and types for the RAM/IO responder slice:
// bus widths, rw encodings, IO addresses, IO region select and
// the TX FIFO occupancy state type.
package ram_io_responder_pkg;

    // Bus widths
    localparam int MEM_DATA_W = 8;
    localparam int ADDR_W     = 32;

    // rw encodings on iMEM_rw
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // IO region: address bits [17:16] == 2'b11
    localparam int         IO_SEL_MSB = 17;
    localparam int         IO_SEL_LSB = 16;
    localparam logic [1:0] IO_SEL     = 2'b11;

    // IO registers
    localparam logic [ADDR_W-1:0] IO_TX_ADDR  = 32'h0003_0000;
    localparam logic [ADDR_W-1:0] IO_END_ADDR = 32'h0003_0004;

    // TX FIFO occupancy
    typedef enum logic [1:0] {
        FIFO_EMPTY       = 2'd0,
        FIFO_PARTIAL     = 2'd1,
        FIFO_ALMOST_FULL = 2'd2,
        FIFO_FULL        = 2'd3
    } fifo_state_e;

    // Classify an occupancy count. ALMOST_FULL covers every non-full count
    // whose free space is within the slack, so the controller sees the
    // almost-full flag early enough to stall with one write still in flight.
    function automatic fifo_state_e classify_occupancy(input int count,
                                                       input int depth,
                                                       input int slack);
        fifo_state_e st;
        if (count == 0) begin
            st = FIFO_EMPTY;
        end else if (count >= depth) begin
            st = FIFO_FULL;
        end else if ((depth - count) <= slack) begin
            st = FIFO_ALMOST_FULL;
        end else begin
            st = FIFO_PARTIAL;
        end
        return st;
    endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// byte_fifo: UART TX byte queue with registered occupancy state.
// Push/pop handshake: a byte leaves when valid_o && pop_ready_i at a rising
// edge; push_i is a request that is accepted whenever there is space, where a
// same-edge pop counts as freeing space first. A push into a full FIFO without
// a pop is dropped and latches the sticky overflow flag.
module byte_fifo
    import ram_io_responder_pkg::*;
#(
    parameter int FIFO_LOG2  = 3,
    parameter int FULL_SLACK = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [7:0]  push_dt_i,
    input  logic        pop_ready_i,
    output logic        valid_o,
    output logic [7:0]  head_o,
    output logic        overflow_o,
    output fifo_state_e state_o
);

    localparam int                 DEPTH   = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] DEPTH_C = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2:0] CNT_ONE = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE = FIFO_LOG2'(1);

    logic [7:0]           store_q [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr_q;
    logic [FIFO_LOG2-1:0] rd_ptr_q;
    logic [FIFO_LOG2:0]   count_q;
    logic [FIFO_LOG2:0]   count_d;
    fifo_state_e          state_q;
    fifo_state_e          state_d;
    logic                 overflow_q;

    logic pop;
    logic push_ok;
    logic drop;

    // Handshake decode, next count and next occupancy state
    always_comb begin
        pop     = (count_q != '0) && pop_ready_i;
        push_ok = push_i && ((count_q != DEPTH_C) || pop);
        drop    = push_i && (count_q == DEPTH_C) && !pop;
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_ok && pop) begin
            count_d = count_q - CNT_ONE;
        end
        state_d = classify_occupancy(int'(count_d), DEPTH, FULL_SLACK);
    end

    // Byte storage; no reset needed because reads are gated by the count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            store_q[wr_ptr_q] <= push_dt_i;
        end
    end

    // Pointers, count, occupancy state and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= FIFO_EMPTY;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= overflow_q | drop;
        end
    end

    assign valid_o    = (count_q != '0);
    assign head_o     = valid_o ? store_q[rd_ptr_q] : 8'h00;
    assign overflow_o = overflow_q;
    assign state_o    = state_q;

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: responder end of the byte-wide CPU memory bus.
// Decodes RAM vs. IO, owns the RAM array, registered read data and the
// program-end flag; IO_TX writes feed a byte_fifo toward the UART.
// Optional feature macro: IO_RX_EN adds a 1-entry RX holding register
// readable at IO_TX_ADDR (data) and IO_END_ADDR (full flag).
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W = 17,
    parameter int FIFO_LOG2  = 3,
    parameter int FULL_SLACK = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
`ifdef IO_RX_EN
    input  logic                  iRX_valid,
    input  logic [MEM_DATA_W-1:0] iRX_dt,
`endif
    input  logic                  iMEM_rw,
    input  logic [ADDR_W-1:0]     iMEM_addr,
    input  logic [MEM_DATA_W-1:0] iMEM_dt,
    output logic [MEM_DATA_W-1:0] oMEM_dt,
    output logic                  oIO_buffer_full,
    output logic                  oTX_valid,
    output logic [MEM_DATA_W-1:0] oTX_dt,
    input  logic                  iTX_ready,
    output logic                  oTX_overflow,
    output logic                  oSIM_end
);

    logic [MEM_DATA_W-1:0] ram_q [1 << RAM_ADDR_W];

    logic [MEM_DATA_W-1:0] mem_dt_q;
    logic [MEM_DATA_W-1:0] mem_dt_d;
    logic                  sim_end_q;

    logic                  io_sel;
    logic                  tx_hit;
    logic                  end_hit;
    logic                  ram_we;
    logic                  tx_push;
    logic                  end_set;
    logic                  rd_en;
    logic [MEM_DATA_W-1:0] io_rd_dt;
    fifo_state_e           fifo_state;

`ifdef IO_RX_EN
    logic                  rx_full_q;
    logic [MEM_DATA_W-1:0] rx_dt_q;
    logic                  rx_take;
`endif

    // Address decode, strobes and next read data
    always_comb begin
        io_sel  = (iMEM_addr[IO_SEL_MSB:IO_SEL_LSB] == IO_SEL);
        tx_hit  = io_sel && (iMEM_addr == IO_TX_ADDR);
        end_hit = io_sel && (iMEM_addr == IO_END_ADDR);
        ram_we  = rdy && (iMEM_rw == RW_WRITE) && !io_sel;
        tx_push = rdy && (iMEM_rw == RW_WRITE) && tx_hit;
        end_set = rdy && (iMEM_rw == RW_WRITE) && end_hit;
        rd_en   = rdy && (iMEM_rw == RW_READ);

        io_rd_dt = '0;
`ifdef IO_RX_EN
        rx_take = rd_en && tx_hit;
        if (tx_hit) begin
            io_rd_dt = rx_full_q ? rx_dt_q : '0;
        end else if (end_hit) begin
            io_rd_dt = {7'b0, rx_full_q};
        end
`endif

        mem_dt_d = mem_dt_q;
        if (rd_en) begin
            mem_dt_d = io_sel ? io_rd_dt : ram_q[iMEM_addr[RAM_ADDR_W-1:0]];
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[iMEM_addr[RAM_ADDR_W-1:0]] <= iMEM_dt;
        end
    end

    // Registered read data and sticky program-end flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_dt_q  <= '0;
            sim_end_q <= 1'b0;
        end else begin
            mem_dt_q  <= mem_dt_d;
            sim_end_q <= sim_end_q | end_set;
        end
    end

`ifdef IO_RX_EN
    // RX holding register: load only when empty, a data read empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_full_q <= 1'b0;
            rx_dt_q   <= '0;
        end else if (!rx_full_q && iRX_valid) begin
            rx_full_q <= 1'b1;
            rx_dt_q   <= iRX_dt;
        end else if (rx_take) begin
            rx_full_q <= 1'b0;
        end
    end
`endif

    byte_fifo #(
        .FIFO_LOG2  (FIFO_LOG2),
        .FULL_SLACK (FULL_SLACK)
    ) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tx_push),
        .push_dt_i   (iMEM_dt),
        .pop_ready_i (iTX_ready),
        .valid_o     (oTX_valid),
        .head_o      (oTX_dt),
        .overflow_o  (oTX_overflow),
        .state_o     (fifo_state)
    );

    // Almost-full is the registered occupancy state, so it already reflects
    // the next-state count of the previous edge.
    assign oIO_buffer_full = (fifo_state == FIFO_ALMOST_FULL) ||
                             (fifo_state == FIFO_FULL);
    assign oMEM_dt  = mem_dt_q;
    assign oSIM_end = sim_end_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Testbench for ram_io_responder: vector table for RAM access and FIFO
// fill/overflow, plus hand-written sequences for push/pop at full,
// asynchronous reset mid-drain, rdy gating, program end and optional RX.
module tb_ram_io_responder;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rw;
    logic [31:0] addr;
    logic [7:0]  dt;
    logic        tx_ready;
    logic [7:0]  mem_dt;
    logic        buf_full;
    logic        tx_valid;
    logic [7:0]  tx_dt;
    logic        tx_ovf;
    logic        sim_end;
`ifdef IO_RX_EN
    logic        rx_valid;
    logic [7:0]  rx_dt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    ram_io_responder dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
`ifdef IO_RX_EN
        .iRX_valid       (rx_valid),
        .iRX_dt          (rx_dt),
`endif
        .iMEM_rw         (rw),
        .iMEM_addr       (addr),
        .iMEM_dt         (dt),
        .oMEM_dt         (mem_dt),
        .oIO_buffer_full (buf_full),
        .oTX_valid       (tx_valid),
        .oTX_dt          (tx_dt),
        .iTX_ready       (tx_ready),
        .oTX_overflow    (tx_ovf),
        .oSIM_end        (sim_end)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [7:0]  dt;
        logic        txr;
        logic [7:0]  e_mem;
        logic        e_full;
        logic        e_valid;
        logic [7:0]  e_txdt;
        logic        e_ovf;
        logic        e_end;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic r, logic [31:0] a, logic [7:0] d, logic t,
                                logic [7:0] em, logic ef, logic ev, logic [7:0] et,
                                logic eo, logic ee);
        vec_t v;
        v.rw = r; v.addr = a; v.dt = d; v.txr = t;
        v.e_mem = em; v.e_full = ef; v.e_valid = ev; v.e_txdt = et;
        v.e_ovf = eo; v.e_end = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_mem, input logic e_full,
                           input logic e_valid, input logic [7:0] e_txdt,
                           input logic e_ovf, input logic e_end);
        chk({tag, ".mem_dt"},   32'(mem_dt),   32'(e_mem));
        chk({tag, ".buf_full"}, 32'(buf_full), 32'(e_full));
        chk({tag, ".tx_valid"}, 32'(tx_valid), 32'(e_valid));
        chk({tag, ".tx_dt"},    32'(tx_dt),    32'(e_txdt));
        chk({tag, ".tx_ovf"},   32'(tx_ovf),   32'(e_ovf));
        chk({tag, ".sim_end"},  32'(sim_end),  32'(e_end));
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic [31:0] a, input logic [7:0] d, input logic t);
        rw = r; addr = a; dt = d; tx_ready = t;
    endtask

    task automatic do_reset(input string tag);
        bus(1'b0, 32'h0, 8'h00, 1'b0);
        rdy = 1'b1;
        rst = 1'b1;
        #1;
        chk_all(tag, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus(1'b0, 32'h0, 8'h00, 1'b0);
`ifdef IO_RX_EN
        rx_valid = 1'b0;
        rx_dt = 8'h00;
`endif

        // Vector table: RAM write/read latency, FIFO fill to overflow
        vecs[0]  = mk(1, 32'h00010, 8'hA5, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(0, 32'h00010, 8'h00, 0, 8'hA5, 0, 0, 8'h00, 0, 0);
        vecs[2]  = mk(1, 32'h00020, 8'h33, 0, 8'hA5, 0, 0, 8'h00, 0, 0);
        vecs[3]  = mk(0, 32'h00020, 8'h00, 0, 8'h33, 0, 0, 8'h00, 0, 0);
        vecs[4]  = mk(1, 32'h30000, 8'h01, 0, 8'h33, 0, 1, 8'h01, 0, 0);
        vecs[5]  = mk(1, 32'h30000, 8'h02, 0, 8'h33, 0, 1, 8'h01, 0, 0);
        vecs[6]  = mk(1, 32'h30000, 8'h03, 0, 8'h33, 0, 1, 8'h01, 0, 0);
        vecs[7]  = mk(1, 32'h30000, 8'h04, 0, 8'h33, 0, 1, 8'h01, 0, 0);
        vecs[8]  = mk(1, 32'h30000, 8'h05, 0, 8'h33, 0, 1, 8'h01, 0, 0);
        vecs[9]  = mk(1, 32'h30000, 8'h06, 0, 8'h33, 1, 1, 8'h01, 0, 0);
        vecs[10] = mk(1, 32'h30000, 8'h07, 0, 8'h33, 1, 1, 8'h01, 0, 0);
        vecs[11] = mk(1, 32'h30000, 8'h08, 0, 8'h33, 1, 1, 8'h01, 0, 0);
        vecs[12] = mk(1, 32'h30000, 8'h09, 0, 8'h33, 1, 1, 8'h01, 1, 0);
        vecs[13] = mk(0, 32'h30000, 8'h00, 0, 8'h00, 1, 1, 8'h01, 1, 0);
        vecs[14] = mk(1, 32'h30008, 8'hFF, 0, 8'h00, 1, 1, 8'h01, 1, 0);

        #1;
        chk_all("reset_init", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            bus(vecs[i].rw, vecs[i].addr, vecs[i].dt, vecs[i].txr);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_mem, vecs[i].e_full,
                    vecs[i].e_valid, vecs[i].e_txdt, vecs[i].e_ovf, vecs[i].e_end);
        end

        // Full FIFO with simultaneous push and pop
        do_reset("reset_b");
        for (int i = 0; i < 8; i++) begin
            bus(1'b1, 32'h30000, 8'(8'h10 + i), 1'b0);
            step();
        end
        chk_all("full8", 8'h00, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        bus(1'b1, 32'h30000, 8'h5A, 1'b1);
        step();
        chk_all("push_pop_full", 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        exp_q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h5A};
        bus(1'b0, 32'h00010, 8'h00, 1'b1);
        for (int n = 0; n < 20; n++) begin
            if (!tx_valid) break;
            if (exp_q.size() == 0) begin
                chk("drain_extra_byte", 32'(tx_dt), 32'h0);
                checks++;
                errors++;
                $display("FAIL drain_extra: got extra byte %0h expected none", tx_dt);
                break;
            end
            chk("drain_byte", 32'(tx_dt), 32'(exp_q.pop_front()));
            step();
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk_all("drained", 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a drain
        do_reset("reset_c");
        bus(1'b1, 32'h00040, 8'hC3, 1'b0);
        step();
        bus(1'b1, 32'h30000, 8'h41, 1'b0); step();
        bus(1'b1, 32'h30000, 8'h42, 1'b0); step();
        bus(1'b1, 32'h30000, 8'h43, 1'b0); step();
        bus(1'b0, 32'h00040, 8'h00, 1'b1);
        step();
        chk_all("after_pop41", 8'hC3, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        bus(1'b0, 32'h00040, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk_all("post_rst_read", 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // rdy low blocks RAM writes and pushes, drain continues
        bus(1'b1, 32'h30000, 8'h77, 1'b0);
        step();
        rdy = 1'b0;
        bus(1'b1, 32'h00040, 8'hEE, 1'b0);
        step();
        chk_all("rdy0_ram_wr", 8'hC3, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        bus(1'b1, 32'h30004, 8'h01, 1'b0);
        step();
        chk_all("rdy0_end_wr", 8'hC3, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
        bus(1'b1, 32'h30000, 8'h99, 1'b1);
        step();
        chk_all("rdy0_tx_wr", 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rdy = 1'b1;
        bus(1'b0, 32'h00040, 8'h00, 1'b0);
        step();
        chk_all("rdy1_ram_rd", 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Program end flag is sticky until reset
        bus(1'b1, 32'h30004, 8'h05, 1'b0);
        step();
        chk("sim_end_set", 32'(sim_end), 32'd1);
        bus(1'b0, 32'h00040, 8'h00, 1'b0);
        step();
        step();
        step();
        chk_all("sim_end_hold", 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        do_reset("reset_e");
        chk("sim_end_clear", 32'(sim_end), 32'd0);

`ifdef IO_RX_EN
        // RX holding register
        rx_valid = 1'b1;
        rx_dt = 8'h7E;
        bus(1'b0, 32'h00040, 8'h00, 1'b0);
        step();
        rx_valid = 1'b0;
        bus(1'b0, 32'h30004, 8'h00, 1'b0);
        step();
        chk("rx_full_flag", 32'(mem_dt), 32'h01);
        bus(1'b0, 32'h30000, 8'h00, 1'b0);
        step();
        chk("rx_read", 32'(mem_dt), 32'h7E);
        step();
        chk("rx_read_empty", 32'(mem_dt), 32'h00);
        bus(1'b0, 32'h30004, 8'h00, 1'b0);
        step();
        chk("rx_flag_clear", 32'(mem_dt), 32'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
